serial_subtractor: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 108 ++++++++++
 tb/tb_serial_subtractor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and bit-counter sizing.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to count 0..width-1, never less than one.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin with borrow-out, the subtract twin of the full adder.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor (diff = a - b - bin) over WIDTH cycles with valid/ready on both sides.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, diff_q;
  logic [CW-1:0]    cnt;
  logic             br, bout_q;
  logic             cell_d, cell_bo;
  logic [WIDTH-1:0] res_nxt;

  full_subtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_bo)
  );

  assign res_nxt = {cell_d, res_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The result is copied to diff_q only on the last bit, so the output never shows a half-built word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      diff_q <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      if (state == IDLE && in_valid) begin
        a_sh <= a;
        b_sh <= b;
        br   <= bin;
        cnt  <= '0;
      end else if (state == SHIFT) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        res_sh <= res_nxt;
        br     <= cell_bo;
        cnt    <= cnt + 1'b1;
        if (cnt == LAST) begin
          diff_q <= res_nxt;
          bout_q <= cell_bo;
`ifdef SERIAL_SUB_OVF_EN
          ovf    <= (a_sh[0] != b_sh[0]) && (cell_d != a_sh[0]);
`endif
        end
      end
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases plus a random stream
// scored against an arithmetic reference model; honours SERIAL_SUB_OVF_EN when defined.
module tb_serial_subtractor;

  localparam int W      = 8;
  localparam int N_OPS  = 1000;
  localparam int LIMIT  = 50000;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         bin;
  logic         out_valid, out_ready;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int   total = 0;
  int   bad   = 0;
  int   lat;
  int   sent, got, pc, cc;
  logic [W-1:0] held_d;
  logic         held_b;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
`ifdef SERIAL_SUB_OVF_EN
    .ovf       (ovf),
`endif
    .bout      (bout)
  );

  // Reference: plain (W+1)-bit and signed integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    exp_t         r;
    logic [W:0]   wide;
    int           s;
    wide = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    s    = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    r.d  = wide[W-1:0];
    r.bo = wide[W];
    r.ov = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got_v, input logic [31:0] want_v);
    total++;
    if (got_v !== want_v) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", tag, got_v, want_v);
    end
  endtask

  // Presents one operand set and returns just after the accepting edge.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tbin);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) checkOutput("accept_timeout", {31'd0, in_ready}, 32'd1);
    a        = ta;
    b        = tbv;
    bin      = tbin;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    bin      = 1'($urandom);
  endtask

  task automatic startOp(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tbin, output int l);
    out_ready = 1'b0;
    applyStimulus(ta, tbv, tbin);
    l = 0;
    while (!out_valid && l < 64) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic finishOp(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    checkOutput({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                          input logic tbin, input logic [W-1:0] ed, input logic eb);
    startOp(ta, tbv, tbin, lat);
    checkOutput({tag, "_latency"}, lat, W);
    checkOutput({tag, "_diff"}, {24'd0, diff}, {24'd0, ed});
    checkOutput({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
    finishOp(tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
    #12;
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_diff", {24'd0, diff}, 32'd0);
    checkOutput("reset_bout", {31'd0, bout}, 32'd0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    directed("basic",      8'h5A, 8'h21, 1'b0, 8'h39, 1'b0);
    directed("underflow",  8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    directed("eq_borrow",  8'h10, 8'h10, 1'b1, 8'hFF, 1'b1);
    directed("equal",      8'hA7, 8'hA7, 1'b0, 8'h00, 1'b0);
    directed("zero_bin",   8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    directed("max_min",    8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);

    // Backpressure: result must hold and new requests must be refused while DONE stalls.
    startOp(8'h5A, 8'h21, 1'b0, lat);
    checkOutput("bp_latency", lat, W);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom);
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      @(posedge clk); #1;
      checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("bp_diff", {24'd0, diff}, 32'h39);
      checkOutput("bp_bout", {31'd0, bout}, 32'd0);
    end
    in_valid = 1'b0;
    finishOp("bp");
    @(posedge clk); #1;
    checkOutput("bp_no_accept", {31'd0, in_ready}, 32'd1);

    // Asynchronous reset in the middle of SHIFT.
    applyStimulus(8'hFF, 8'h0F, 1'b0);
    repeat (3) @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("arst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("arst_diff", {24'd0, diff}, 32'd0);
    checkOutput("arst_bout", {31'd0, bout}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    directed("post_reset", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);

`ifdef SERIAL_SUB_OVF_EN
    startOp(8'h80, 8'h01, 1'b0, lat);
    checkOutput("ovf1_diff", {24'd0, diff}, 32'h7F);
    checkOutput("ovf1_bout", {31'd0, bout}, 32'd0);
    checkOutput("ovf1_ovf", {31'd0, ovf}, 32'd1);
    finishOp("ovf1");
    startOp(8'h7F, 8'h01, 1'b0, lat);
    checkOutput("ovf0_diff", {24'd0, diff}, 32'h7E);
    checkOutput("ovf0_ovf", {31'd0, ovf}, 32'd0);
    finishOp("ovf0");
`endif

    // Random stream with consumer stalls, scoreboarded in order.
    sent = 0; got = 0; pc = 0; cc = 0;
    fork
      begin
        while (sent < N_OPS && pc < LIMIT) begin
          @(posedge clk); #1;
          pc++;
          if (in_ready && $urandom_range(0, 3) != 0) begin
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            in_valid = 1'b1;
            q.push_back(model(a, b, bin));
            sent++;
          end else begin
            in_valid = in_ready ? 1'b0 : 1'($urandom);
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
          end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      begin
        while (got < N_OPS && cc < LIMIT) begin
          @(posedge clk); #1;
          cc++;
          out_ready = ($urandom_range(0, 2) != 0);
          if (out_valid && out_ready) begin
            if (q.size() == 0) begin
              checkOutput("stream_extra", 32'd1, 32'd0);
            end else begin
              e = q.pop_front();
              checkOutput("stream_diff", {24'd0, diff}, {24'd0, e.d});
              checkOutput("stream_bout", {31'd0, bout}, {31'd0, e.bo});
`ifdef SERIAL_SUB_OVF_EN
              checkOutput("stream_ovf", {31'd0, ovf}, {31'd0, e.ov});
`endif
            end
            got++;
          end
        end
      end
    join
    out_ready = 1'b0;
    checkOutput("stream_count", got, N_OPS);
    checkOutput("stream_leftover", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
